// File: rtl/dcache_controller.sv
// dcache_controller: 2-way, 16-set write-back data cache controller.
// Drives an external tag/data SRAM and a line-wide memory port.
module dcache_controller (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         cpu_req_i,
   input  logic         cpu_write_i,
   input  logic [31:0]  cpu_addr_i,
   input  logic [31:0]  cpu_data_i,
   output logic [31:0]  cpu_data_o,
   output logic         cpu_stall_o,
   output logic         sram_enable_o,
   output logic         sram_write_o,
   output logic [3:0]   sram_addr_o,
   output logic [24:0]  sram_tag_o,
   output logic [255:0] sram_data_o,
   input  logic [24:0]  sram_tag_i,
   input  logic [255:0] sram_data_i,
   input  logic         sram_hit_i,
   output logic         mem_enable_o,
   output logic         mem_write_o,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o,
   input  logic [255:0] mem_data_i,
   input  logic         mem_ack_i,
   output logic [15:0]  hit_cnt_o,
   output logic [15:0]  miss_cnt_o
);

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WBACK,
      REFILL,
      FILL
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [22:0]    victim_tag_q;
   logic [255:0]   victim_data_q;
   logic [255:0]   refill_q;
   logic [22:0]    tag;
   logic [3:0]     idx;
   logic [2:0]     word;
   logic           hit_now;
   logic           miss_now;
   logic [255:0]   merged;
   logic           addr_unused;

   assign tag  = cpu_addr_i[31:9];
   assign idx  = cpu_addr_i[8:5];
   assign word = cpu_addr_i[4:2];
   assign addr_unused = ^cpu_addr_i[1:0];

   assign hit_now  = (state_q == IDLE) && cpu_req_i && sram_hit_i;
   assign miss_now = (state_q == IDLE) && cpu_req_i && !sram_hit_i;

   // Kept out of the FSM block so SRAM hit logic never loops back on itself
   assign sram_enable_o = (state_q != IDLE) || cpu_req_i;
   assign sram_addr_o   = idx;
   assign cpu_data_o    = sram_data_i[{word, 5'b0} +: 32];

   always_comb begin
      merged = sram_data_i;
      merged[{word, 5'b0} +: 32] = cpu_data_i;
   end

   always_comb begin
      state_d      = state_q;
      cpu_stall_o  = 1'b1;
      sram_write_o = 1'b0;
      sram_tag_o   = {2'b10, tag};
      sram_data_o  = sram_data_i;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = {tag, idx, 5'b0};
      mem_data_o   = victim_data_q;
      unique case (state_q)
         IDLE: begin
            cpu_stall_o = miss_now;
            if (hit_now && cpu_write_i) begin
               sram_write_o = 1'b1;
               sram_tag_o   = {2'b11, tag};
               sram_data_o  = merged;
            end
            if (miss_now) state_d = MISS;
         end
         MISS: begin
            if (sram_tag_i[24] && sram_tag_i[23]) state_d = WBACK;
            else                                  state_d = REFILL;
         end
         WBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {victim_tag_q, idx, 5'b0};
            if (mem_ack_i) state_d = REFILL;
         end
         REFILL: begin
            mem_enable_o = 1'b1;
            if (mem_ack_i) state_d = FILL;
         end
         FILL: begin
            sram_write_o = 1'b1;
            sram_data_o  = refill_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         victim_tag_q  <= '0;
         victim_data_q <= '0;
         refill_q      <= '0;
         hit_cnt_o     <= '0;
         miss_cnt_o    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == MISS) begin
            victim_tag_q  <= sram_tag_i[22:0];
            victim_data_q <= sram_data_i;
         end
         if (state_q == REFILL && mem_ack_i) refill_q <= mem_data_i;
         if (hit_now && hit_cnt_o != 16'hFFFF)
            hit_cnt_o <= hit_cnt_o + 16'd1;
         if (miss_now && miss_cnt_o != 16'hFFFF)
            miss_cnt_o <= miss_cnt_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: random and directed checks of dcache_controller
// against a 2-way LRU SRAM, a latency memory and a queue-based cache model.
module tb_dcache_controller;

   logic         clk;
   logic         rst;
   logic         cpu_req;
   logic         cpu_write;
   logic [31:0]  cpu_addr;
   logic [31:0]  cpu_wdata;
   logic [31:0]  cpu_rdata;
   logic         cpu_stall;
   logic         sram_enable;
   logic         sram_write;
   logic [3:0]   sram_addr;
   logic [24:0]  sram_tag_w;
   logic [255:0] sram_data_w;
   logic [24:0]  sram_tag_r;
   logic [255:0] sram_data_r;
   logic         sram_hit;
   logic         mem_enable;
   logic         mem_write;
   logic [31:0]  mem_addr;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata;
   logic         mem_ack;
   logic [15:0]  hit_cnt;
   logic [15:0]  miss_cnt;

   dcache_controller dut (
      .clk_i(clk), .rst_i(rst),
      .cpu_req_i(cpu_req), .cpu_write_i(cpu_write),
      .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
      .cpu_data_o(cpu_rdata), .cpu_stall_o(cpu_stall),
      .sram_enable_o(sram_enable), .sram_write_o(sram_write),
      .sram_addr_o(sram_addr), .sram_tag_o(sram_tag_w),
      .sram_data_o(sram_data_w), .sram_tag_i(sram_tag_r),
      .sram_data_i(sram_data_r), .sram_hit_i(sram_hit),
      .mem_enable_o(mem_enable), .mem_write_o(mem_write),
      .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
      .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
      .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [255:0] got,
                      input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [29:0] wa);
      return (32'(wa) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // ---------------- SRAM: 16 sets x 2 ways, LRU ----------------
   logic [24:0]  s_tag  [16][2];
   logic [255:0] s_data [16][2];
   logic         s_lru  [16];
   logic         hit_way;
   logic         sel_way;

   always_comb begin
      sram_hit = 1'b0;
      hit_way  = 1'b0;
      for (int w = 0; w < 2; w++)
         if (sram_enable && s_tag[sram_addr][w][24] &&
             s_tag[sram_addr][w][22:0] == cpu_addr[31:9]) begin
            sram_hit = 1'b1;
            hit_way  = w[0];
         end
      sel_way     = sram_hit ? hit_way : s_lru[sram_addr];
      sram_tag_r  = s_tag[sram_addr][sel_way];
      sram_data_r = s_data[sram_addr][sel_way];
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < 16; s++) begin
            s_lru[s] <= 1'b0;
            for (int w = 0; w < 2; w++) s_tag[s][w] <= '0;
         end
      end else if (sram_enable) begin
         if (sram_write) begin
            s_tag[sram_addr][sel_way]  <= sram_tag_w;
            s_data[sram_addr][sel_way] <= sram_data_w;
            s_lru[sram_addr]           <= ~sel_way;
         end else if (sram_hit) begin
            s_lru[sram_addr] <= ~hit_way;
         end
      end
   end

   // ---------------- memory with programmable latency ----------------
   logic [255:0] back_mem [logic [26:0]];
   logic [31:0]  wb_addr_q [$];
   logic [255:0] wb_data_q [$];
   int           mem_lat = 3;
   int           mcnt = 0;
   int           stray_cnt = 0;
   int           stray_done = 0;
   logic [31:0]  m_addr0;
   logic         m_w0;

   function automatic logic [255:0] mem_line(input logic [26:0] la);
      logic [255:0] l;
      if (back_mem.exists(la)) return back_mem[la];
      for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word({la, 3'(w)});
      return l;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         mem_ack = 1'b0;
         mcnt    = 0;
      end else if (mem_ack) begin
         mem_ack = 1'b0;
         if (!m_w0) chk("mem_deassert", mem_enable, 0);
      end else if (stray_cnt != stray_done) begin
         mem_ack = 1'b1;
         stray_done++;
      end else if (mem_enable) begin
         if (mcnt == 0) begin
            m_addr0 = mem_addr;
            m_w0    = mem_write;
         end
         mcnt++;
         if (mcnt >= mem_lat) begin
            chk("mem_stable", {mem_write, mem_addr}, {m_w0, m_addr0});
            chk("mem_align", mem_addr[4:0], 0);
            if (mem_write) begin
               back_mem[mem_addr[31:5]] = mem_wdata;
               wb_addr_q.push_back(mem_addr);
               wb_data_q.push_back(mem_wdata);
            end else begin
               mem_rdata = mem_line(mem_addr[31:5]);
            end
            mem_ack = 1'b1;
            mcnt    = 0;
         end
      end else begin
         mcnt = 0;
      end
   end

   // ---------------- reference model: per-set MRU queues ----------------
   typedef struct {
      logic [22:0] tag;
      bit          dirty;
   } ent_t;

   ent_t         mq [16][$];
   logic [31:0]  ref_mem [logic [29:0]];
   logic [15:0]  exp_hit = 0;
   logic [15:0]  exp_miss = 0;
   logic [31:0]  last_wb_addr;
   logic [255:0] last_wb_data;

   function automatic logic [31:0] rd_word(input logic [29:0] wa);
      return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
   endfunction

   function automatic logic [255:0] ref_line(input logic [26:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[32*w +: 32] = rd_word({la, 3'(w)});
      return l;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 16; s++) mq[s].delete();
      exp_hit  = 0;
      exp_miss = 0;
   endtask

   task automatic model_access(input bit w, input logic [31:0] a,
                               input logic [31:0] d,
                               output logic [31:0] exp_rd,
                               output bit exp_wb,
                               output logic [31:0] wb_a);
      int   s;
      int   pos;
      ent_t e;
      s      = int'(a[8:5]);
      pos    = -1;
      exp_wb = 1'b0;
      wb_a   = '0;
      for (int i = 0; i < mq[s].size(); i++)
         if (mq[s][i].tag == a[31:9]) pos = i;
      if (pos >= 0) begin
         e = mq[s][pos];
         mq[s].delete(pos);
      end else begin
         if (exp_miss != 16'hFFFF) exp_miss++;
         if (mq[s].size() == 2) begin
            e = mq[s].pop_back();
            if (e.dirty) begin
               exp_wb = 1'b1;
               wb_a   = {e.tag, a[8:5], 5'b0};
            end
         end
         e.tag   = a[31:9];
         e.dirty = 1'b0;
      end
      if (w) e.dirty = 1'b1;
      mq[s].push_front(e);
      if (exp_hit != 16'hFFFF) exp_hit++;
      exp_rd = rd_word(a[31:2]);
      if (w) ref_mem[a[31:2]] = d;
   endtask

   // One CPU access, started just after a falling edge
   task automatic do_access(input bit w, input logic [31:0] a,
                            input logic [31:0] d);
      logic [31:0] er;
      logic [31:0] wa;
      bit          ewb;
      bit          done;
      int          n;
      model_access(w, a, d, er, ewb, wa);
      wb_addr_q.delete();
      wb_data_q.delete();
      cpu_req   = 1'b1;
      cpu_write = w;
      cpu_addr  = a;
      cpu_wdata = d;
      done = 1'b0;
      n    = 0;
      while (!done && n < 300) begin
         #1;
         if (!cpu_stall) begin
            done = 1'b1;
            if (w) chk("store_we", sram_write, 1);
            else   chk("load_data", cpu_rdata, er);
         end
         @(negedge clk);
         n++;
      end
      cpu_req = 1'b0;
      chk("access_done", done, 1);
      chk("wb_count", wb_addr_q.size(), ewb);
      if (ewb && wb_addr_q.size() == 1) begin
         last_wb_addr = wb_addr_q[0];
         last_wb_data = wb_data_q[0];
         chk("wb_addr", wb_addr_q[0], wa);
         chk("wb_data", wb_data_q[0], ref_line(wa[31:5]));
      end
   endtask

   initial begin
      logic [31:0] er;
      logic [31:0] wa;
      bit          ewb;
      bit          seen;
      int          cnt;

      rst = 1'b0;
      cpu_req = 1'b0;
      cpu_write = 1'b0;
      cpu_addr = '0;
      cpu_wdata = '0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      #2 rst = 1'b1;
      #1;
      chk("rst_mem_en", mem_enable, 0);
      chk("rst_sram_we", sram_write, 0);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_hit_cnt", hit_cnt, 0);
      chk("rst_miss_cnt", miss_cnt, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();

      // clean miss on set 1, 10-cycle refill
      mem_lat = 10;
      model_access(1'b0, 32'h20, 32'h0, er, ewb, wa);
      cpu_req  = 1'b1;
      cpu_addr = 32'h20;
      #1;
      chk("miss_stall", cpu_stall, 1);
      chk("miss_no_we", sram_write, 0);
      @(negedge clk); #1;
      chk("miss_st_mem", mem_enable, 0);
      @(negedge clk); #1;
      chk("refill_en", {mem_enable, mem_write}, 2'b10);
      chk("refill_addr", mem_addr, 32'h20);
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk); #1;
         seen = sram_write;
      end
      chk("fill_seen", seen, 1);
      chk("fill_tag", sram_tag_w, {2'b10, 23'h0});
      chk("fill_data", sram_data_w, mem_line(27'h1));
      chk("fill_stall", cpu_stall, 1);
      @(negedge clk); #1;
      chk("relookup_stall", cpu_stall, 0);
      chk("relookup_data", cpu_rdata, er);
      @(negedge clk);
      cpu_req = 1'b0;
      chk("r40_miss_cnt", miss_cnt, 1);
      chk("r40_hit_cnt", hit_cnt, 1);

      // single-cycle store hit
      model_access(1'b1, 32'h24, 32'hDEADBEEF, er, ewb, wa);
      cpu_req   = 1'b1;
      cpu_write = 1'b1;
      cpu_addr  = 32'h24;
      cpu_wdata = 32'hDEADBEEF;
      #1;
      chk("st_stall", cpu_stall, 0);
      chk("st_we", sram_write, 1);
      chk("st_tag", sram_tag_w, {2'b11, 23'h0});
      chk("st_word1", sram_data_w[63:32], 32'hDEADBEEF);
      chk("st_word0", sram_data_w[31:0], init_word(30'h8));
      @(negedge clk);
      cpu_req   = 1'b0;
      cpu_write = 1'b0;
      chk("st_hit_cnt", hit_cnt, 2);

      // dirty eviction of set 1
      mem_lat = 4;
      do_access(1'b0, 32'h420, 32'h0);
      last_wb_addr = '0;
      last_wb_data = '0;
      do_access(1'b0, 32'h820, 32'h0);
      chk("r42_wb_addr", last_wb_addr, 32'h20);
      chk("r42_wb_word1", last_wb_data[63:32], 32'hDEADBEEF);

      // randomized traffic over a small conflicting address pool
      for (int k = 0; k < 250; k++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 3)) << 9) |
             (32'($urandom_range(0, 3)) << 5) |
             (32'($urandom_range(0, 7)) << 2);
         mem_lat = $urandom_range(1, 6);
         do_access(1'($urandom_range(0, 1)), a, $urandom);
      end
      chk("rand_hit_cnt", hit_cnt, exp_hit);
      chk("rand_miss_cnt", miss_cnt, exp_miss);

      // reset during refill
      mem_lat  = 50;
      cpu_req  = 1'b1;
      cpu_addr = 32'h0BAD_00A0;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk); #1;
         seen = mem_enable && !mem_write;
      end
      chk("r43_refill", seen, 1);
      rst = 1'b1;
      #1;
      chk("r43_mem_en", mem_enable, 0);
      chk("r43_sram_we", sram_write, 0);
      cpu_req = 1'b0;
      #1;
      chk("r43_stall", cpu_stall, 0);
      chk("r43_cnts", {hit_cnt, miss_cnt}, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      wb_addr_q.delete();
      wb_data_q.delete();
      stray_cnt++;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         if (sram_write || mem_enable || cpu_stall) cnt++;
      end
      chk("r43_stray_ack", cnt, 0);

      // counter saturation under back-to-back hits
      mem_lat = 2;
      do_access(1'b0, 32'h1000_0000, 32'h0);
      cpu_req  = 1'b1;
      cpu_addr = 32'h1000_0000;
      repeat (70000) @(negedge clk);
      cpu_req = 1'b0;
      #1;
      chk("sat_hit_cnt", hit_cnt, 16'hFFFF);
      chk("sat_miss_cnt", miss_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 Parameters: none; geometry is fixed at 16 sets, 2 ways, 32-byte lines, 32-bit addresses, and tag word {valid, dirty, tag[22:0]}.
REQ-002 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  in  1  reset, asynchronous and active-high.
REQ-004 cpu_req_i  in  1  CPU access request; held stable with the address/data/write inputs while cpu_stall_o=1.
REQ-005 cpu_write_i  in  1  1=store, 0=load.
REQ-006 cpu_addr_i  in  32  byte address: tag=[31:9], index=[8:5], word=[4:2].
REQ-007 cpu_data_i  in  32  store data.
REQ-008 cpu_data_o  out  32  load data, the selected word of sram_data_i.
REQ-009 cpu_stall_o  out  1  CPU must hold its request.
REQ-010 sram_enable_o / sram_write_o  out  1/1  cache SRAM enable and write strobe.
REQ-011 sram_addr_o  out  4  set index.
REQ-012 sram_tag_o  out  25  tag word to compare and write.
REQ-013 sram_data_o  out  256  line to write.
REQ-014 sram_tag_i / sram_data_i / sram_hit_i  in  25/256/1  SRAM tag, line and hit result (combinational).
REQ-015 mem_enable_o / mem_write_o  out  1/1  memory request and direction.
REQ-016 mem_addr_o  out  32  line-aligned address, with [4:0]=0.
REQ-017 mem_data_o  out  256  writeback line.
REQ-018 mem_data_i / mem_ack_i  in  256/1  refill line, and the one-cycle completion pulse.
REQ-019 hit_cnt_o / miss_cnt_o  out  16/16  saturating access statistics.

Function
REQ-020 The FSM states SHALL be IDLE, MISS, WBACK, REFILL and FILL.
REQ-021 In IDLE, sram_enable_o SHALL equal cpu_req_i, sram_addr_o SHALL be the index, and sram_tag_o SHALL be {1, 0, addr tag}.
REQ-022 Load hit in IDLE: cpu_stall_o=0 and cpu_data_o=sram_data_i[32*word +: 32] in the same cycle, with zero added latency.
REQ-023 Store hit in IDLE: the same cycle SHALL assert sram_write_o with the line merged from cpu_data_i at the word offset, sram_tag_o={1,1,tag}, and cpu_stall_o=0.
REQ-024 Miss in IDLE (cpu_req_i=1, sram_hit_i=0): cpu_stall_o=1, sram_write_o=0, and the next state SHALL be MISS.
REQ-025 MISS: latch the victim sram_tag_i and sram_data_i; go to WBACK if the victim valid=1 and dirty=1, otherwise go to REFILL.
REQ-026 WBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=the latched victim line; go to REFILL on mem_ack_i.
REQ-027 REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}; on mem_ack_i, latch mem_data_i and go to FILL.
REQ-028 FILL: for one cycle, sram_enable_o=1, sram_write_o=1, sram_tag_o={1,0,tag}, sram_data_o=the refill line; then return to IDLE.
REQ-029 On return to IDLE, the held request SHALL re-lookup, hit, and complete with the REQ-022/023 timing.
REQ-030 mem_enable_o and the mem address/data SHALL stay stable from assertion until the cycle mem_ack_i is sampled; the block deasserts mem_enable_o the cycle after the ack.
REQ-031 mem_ack_i outside WBACK/REFILL SHALL be ignored.
REQ-032 cpu_stall_o SHALL be 1 in every state except IDLE.
REQ-033 cpu_stall_o SHALL be 0 in IDLE when cpu_req_i=0.
REQ-034 hit_cnt_o SHALL increment once per completed access in IDLE; miss_cnt_o SHALL increment once per IDLE->MISS transition.
REQ-035 Both counters SHALL saturate at 16'hFFFF.
REQ-036 The access that completes after a refill SHALL count as a hit.

Reset
REQ-037 rst_i=1 SHALL immediately force IDLE, zero the counters and latches, and drive mem_enable_o=0, sram_write_o=0 and cpu_stall_o=0 (with cpu_req_i=0).
REQ-038 Reset mid-WBACK or mid-REFILL SHALL abandon the memory transaction; a later mem_ack_i is ignored per REQ-031.
REQ-039 The block SHALL not reset SRAM contents; the SRAM resets them on the shared rst_i.

Verification
REQ-040 Reset, then load 0x0000_0020 (clean miss, set 1): MISS->REFILL with mem_addr_o=0x0000_0020; mem_ack_i after 10 cycles -> FILL writes tag {1,0,23'h0}; the load returns word 0 next cycle; miss_cnt=1, hit_cnt=1.
REQ-041 Store 0xDEADBEEF to 0x0000_0024 after the REQ-040 line: single-cycle write, line word1=0xDEADBEEF, tag dirty=1, no stall.
REQ-042 Evict the dirty line (both ways of set 1 occupied, load 0x0000_0420 then 0x0000_0820): WBACK with mem_write_o=1 and the victim address, mem_data_o word1=0xDEADBEEF; then REFILL.
REQ-043 Assert rst_i during REFILL: mem_enable_o drops in the same cycle, the FSM is in IDLE, and a stray mem_ack_i causes no SRAM write.
REQ-044 Issue 70000 back-to-back load hits: hit_cnt_o holds at 16'hFFFF.
